// File: rtl/lcd_pkg.sv
// Shared definitions for the character LCD digit driver.
//   - lcd_state_t : sequencer states (power-up wait, init, clear wait,
//                   address set, character write, idle)
//   - wr_phase_t  : phases of the 3-cycle byte write strobe
//   - HD44780 command bytes and the ASCII codes used for hex digits
//   - nib2ascii() : hex nibble to ASCII character
//   - init_cmd()  : init command byte by position in the init sequence
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    INIT     = 3'd1,
    CLR_WAIT = 3'd2,
    SET_ADDR = 3'd3,
    WR_CHAR  = 3'd4,
    IDLE     = 3'd5
  } lcd_state_t;

  // PH_SETUP/PH_STROBE/PH_HOLD are the three visible phases of one byte:
  // bus set up with E low, E high, E low with bus held.
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_STROBE = 2'd2,
    PH_HOLD   = 2'd3
  } wr_phase_t;

  localparam logic [7:0] FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] DISP_ON    = 8'h0C;  // display on, cursor off
  localparam logic [7:0] ENTRY_MODE = 8'h06;  // increment address, no shift
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] SET_DDRAM  = 8'h80;

  localparam logic [7:0] ZERO    = 8'h30;
  localparam logic [7:0] ALPHA_A = 8'h41;
  localparam logic [7:0] SPACE   = 8'h20;

  localparam int INIT_CMDS = 4;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ZERO + {4'h0, nib};
    else             return ALPHA_A + {4'h0, nib} - 8'd10;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY_MODE;
      default: return CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Three-cycle LCD byte write: bus set up (E=0), strobe (E=1), hold (E=0).
// A start seen while idle or in the hold phase begins the next byte's
// setup phase on the following edge, so bytes can run back to back.
// Ports:
//   clk_1ms, reset      : clock, asynchronous active-high reset
//   start, rs, data_byte: request a write of data_byte with register select rs
//   done                : high during the hold phase (last cycle of a byte)
//   lcd_e, lcd_rs, lcd_db: registered LCD pins; rs/db hold between writes
module lcd_byte_writer
  import lcd_pkg::*;
(
  input  logic       clk_1ms,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data_byte,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_db
);

  wr_phase_t phase;

  // NOTE: registered state uses non-blocking (<=) so every flop sees the
  // values from before the edge, whatever order the statements run in.
  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      phase  <= PH_IDLE;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_db <= 8'h00;
    end else begin
      case (phase)
        PH_IDLE, PH_HOLD: begin
          lcd_e <= 1'b0;
          if (start) begin
            phase  <= PH_SETUP;
            lcd_rs <= rs;
            lcd_db <= data_byte;
          end else begin
            phase  <= PH_IDLE;
          end
        end
        PH_SETUP: begin
          phase <= PH_STROBE;
          lcd_e <= 1'b1;
        end
        PH_STROBE: begin
          phase <= PH_HOLD;
          lcd_e <= 1'b0;
        end
        default: begin
          phase <= PH_IDLE;
          lcd_e <= 1'b0;
        end
      endcase
    end
  end

  assign done = (phase == PH_HOLD);

endmodule

// File: rtl/lcd_digit_driver.sv
// HD44780-class character LCD driver showing DIGITS hex characters.
// Runs the power-up wait and init sequence, then writes one frame (DDRAM
// address + DIGITS characters) per accepted update. Updates arriving while
// a frame is in flight park in a single pending slot (newest wins) and are
// snapshotted into the active register only when the next frame starts.
// Ports:
//   clk_1ms, reset : 1 ms clock, asynchronous active-high reset
//   data           : packed nibbles, data[4*DIGITS-1 -: 4] is leftmost
//   data_valid     : update request, sampled every edge
//   lz_blank       : blank leading zeros (rightmost digit always shown)
//   busy           : high until the current frame has completed
//   frame_done     : one-cycle pulse after each frame's last character
//   E, RW, RS, DB  : LCD pins (RW tied low, write only)
module lcd_digit_driver
  import lcd_pkg::*;
#(
  parameter int         DIGITS        = 4,
  parameter logic [7:0] START_ADDR    = 8'h00,
  parameter int         INIT_WAIT_MS  = 20,
  parameter int         CLEAR_WAIT_MS = 2
) (
  input  logic                clk_1ms,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] data,
  input  logic                data_valid,
  input  logic                lz_blank,
  output logic                busy,
  output logic                frame_done,
  output logic                E,
  output logic                RW,
  output logic                RS,
  output logic [7:0]          DB
);

  localparam int MAX_WAIT = (INIT_WAIT_MS > CLEAR_WAIT_MS) ? INIT_WAIT_MS : CLEAR_WAIT_MS;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam int IDX_W    = 5;

  lcd_state_t          state, state_next;
  logic [CNT_W-1:0]    wait_cnt;
  logic [2:0]          cmd_cnt;
  logic [IDX_W-1:0]    char_cnt;
  logic [4*DIGITS-1:0] active_data, pend_data, snap_data;
  logic                pend_flag, pend_any;

  logic                wr_start, wr_rs, wr_done;
  logic [7:0]          wr_byte;
  logic                issue_addr, issue_char, frame_end;

  logic [3:0]          char_nib;
  logic                char_lead;
  logic [7:0]          char_byte;

  // A request in the current cycle counts as pending, which lets a request
  // coinciding with the last character's hold phase chain a new frame.
  assign pend_any  = pend_flag | data_valid;
  assign snap_data = data_valid ? data : pend_data;

  // Select the next character and flag whether every nibble up to and
  // including it is zero (candidate for leading-zero blanking).
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    char_nib  = 4'h0;
    char_lead = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      zero_run = zero_run & (active_data[4*(DIGITS-1-i) +: 4] == 4'h0);
      if (char_cnt == IDX_W'(i)) begin
        char_nib  = active_data[4*(DIGITS-1-i) +: 4];
        char_lead = zero_run;
      end
    end
  end

  assign char_byte = (lz_blank && char_lead && (char_cnt != IDX_W'(DIGITS - 1)))
                   ? SPACE : nib2ascii(char_nib);

  // Each state issues the next byte in the same cycle the previous byte is
  // in its hold phase (or the wait expires), so bytes follow back to back.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is
    // inferred on paths that do not assign it.
    state_next = state;
    wr_start   = 1'b0;
    wr_rs      = 1'b0;
    wr_byte    = 8'h00;
    issue_addr = 1'b0;
    issue_char = 1'b0;
    frame_end  = 1'b0;

    case (state)
      PWR_WAIT: begin
        if (wait_cnt == CNT_W'(INIT_WAIT_MS)) begin
          wr_start   = 1'b1;
          wr_byte    = init_cmd(2'd0);
          state_next = INIT;
        end
      end
      INIT: begin
        if (wr_done) begin
          if (cmd_cnt == 3'(INIT_CMDS)) begin
            state_next = CLR_WAIT;
          end else begin
            wr_start = 1'b1;
            wr_byte  = init_cmd(cmd_cnt[1:0]);
          end
        end
      end
      CLR_WAIT: begin
        if (wait_cnt == CNT_W'(CLEAR_WAIT_MS)) issue_addr = 1'b1;
      end
      SET_ADDR: begin
        if (wr_done) begin
          issue_char = 1'b1;
          state_next = WR_CHAR;
        end
      end
      WR_CHAR: begin
        if (wr_done) begin
          if (char_cnt == IDX_W'(DIGITS)) begin
            frame_end = 1'b1;
            if (pend_any) issue_addr = 1'b1;
            else          state_next = IDLE;
          end else begin
            issue_char = 1'b1;
          end
        end
      end
      IDLE: begin
        if (data_valid) issue_addr = 1'b1;
      end
      default: state_next = PWR_WAIT;
    endcase

    if (issue_addr) begin
      wr_start   = 1'b1;
      wr_byte    = SET_DDRAM | START_ADDR;
      state_next = SET_ADDR;
    end
    if (issue_char) begin
      wr_start = 1'b1;
      wr_rs    = 1'b1;
      wr_byte  = char_byte;
    end
  end

  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      state       <= PWR_WAIT;
      wait_cnt    <= '0;
      cmd_cnt     <= 3'd0;
      char_cnt    <= '0;
      active_data <= '0;
      pend_data   <= '0;
      pend_flag   <= 1'b0;
      busy        <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= frame_end;
      // Stays high through the frame_done cycle; drops one cycle later
      // unless a new request arrives.
      busy       <= (state != IDLE) || data_valid;

      if (state_next == CLR_WAIT && state != CLR_WAIT)
        wait_cnt <= CNT_W'(1);
      else if (state == PWR_WAIT || state == CLR_WAIT)
        wait_cnt <= wait_cnt + 1'b1;

      if (wr_start && (state == PWR_WAIT || state == INIT))
        cmd_cnt <= cmd_cnt + 3'd1;

      if (issue_addr)      char_cnt <= '0;
      else if (issue_char) char_cnt <= char_cnt + 1'b1;

      // Snapshot at frame start so a frame never mixes old and new data.
      if (issue_addr && pend_any) begin
        active_data <= snap_data;
        pend_flag   <= 1'b0;
      end else if (data_valid) begin
        pend_data <= data;
        pend_flag <= 1'b1;
      end
    end
  end

  lcd_byte_writer u_writer (
    .clk_1ms   (clk_1ms),
    .reset     (reset),
    .start     (wr_start),
    .rs        (wr_rs),
    .data_byte (wr_byte),
    .done      (wr_done),
    .lcd_e     (E),
    .lcd_rs    (RS),
    .lcd_db    (DB)
  );

  assign RW = 1'b0;

endmodule
